xtal_clock_qualifier: RTL and testbench
=======================================

// Module: xtal_clock_qualifier
// PURPOSE
//  Sits directly downstream of the crystal DDR oscillator stage and consumes its ClockP/ClockN pair.
//  Samples both phases on an independent reference clock and measures the edge rate over fixed windows.
//  Declares the crystal clock good only after GOOD_WINDOWS consecutive in-range windows.
//  Flags loss of oscillation, wrong frequency and (optionally) broken complementarity.
//  Drives ClockOk and a sticky Fault to the clock-switch/reset sequencer.
// PARAMETERS
//  WINDOW        256  measurement window length, in Clock cycles
//  MIN_EDGES      60  minimum rising ClockP edges per window for a good window
//  MAX_EDGES      68  maximum rising ClockP edges per window for a good window
//  GOOD_WINDOWS    4  consecutive good windows required to reach LOCKED
//  SKEW_TOL        3  max consecutive cycles with synced ClockP==ClockN tolerated
//  CNT_W           9  width of the edge counter and of LastEdgeCount
// PORTS
//  Clock          in   1      reference clock (free-running, independent of the crystal)
//  Reset          in   1      synchronous, active-high reset
//  ClockP         in   1      oscillator positive phase (asynchronous to Clock)
//  ClockN         in   1      oscillator negative phase (asynchronous to Clock)
//  FaultClear     in   1      pulse: clears sticky Fault
//  ClockOk        out  1      1 while State==LOCKED
//  Fault          out  1      sticky: a loss of lock occurred
//  State          out  2      0=WARMUP 1=LOCKED 2=FAULT
//  LastEdgeCount  out  CNT_W  edge count of the most recently completed window
// BEHAVIOUR
//  - Reset is synchronous, active-high: ClockOk=0, Fault=0, State=WARMUP, LastEdgeCount=0.
//    Reset also clears the synchronizers, window counter, edge counter, good-window counter and skew counter.
//    Reset mid-window discards the partial window.
//  - Synchronization: ClockP and ClockN each pass through a 2-flop synchronizer on Clock.
//    A rising edge is syncP==1 with its previous registered value ==0.
//  - Window: a counter runs 0..WINDOW-1 and wraps. Each cycle with a rising edge adds 1 to the edge count.
//    The edge count saturates at 2^CNT_W-1.
//    An edge seen in the last window cycle counts toward that window.
//  - At window end: LastEdgeCount <= final count and the edge count restarts at 0.
//    good = MIN_EDGES <= count <= MAX_EDGES (inclusive).
//  - WARMUP:
//    - good window: good counter +1.
//    - bad window: good counter cleared.
//    - good counter reaches GOOD_WINDOWS -> LOCKED; ClockOk=1 from the next cycle.
//  - LOCKED:
//    - bad window -> FAULT.
//    - complement fault -> FAULT immediately, and the window restarts.
//  - Entering FAULT: ClockOk=0 and Fault=1 on the next edge. The good counter is cleared.
//  - FAULT: stays for one full window (restarted at entry), then -> WARMUP regardless of that count.
//  - A complement fault or bad window in WARMUP clears the good counter only.
//    It does not set Fault.
//  - Fault clear: FaultClear clears Fault. If a new fault sets Fault in the same cycle, set wins.
//  - Complement fault and window end in the same cycle: the complement fault takes priority.
//  - Latency: ClockOk lags actual oscillator start by at most 2 sync cycles + (GOOD_WINDOWS+1)*WINDOW.
// CONFIGURATION
//  XTAL_QUAL_COMPLEMENT_CHECK_EN defined:
//    - A skew counter increments while syncP==syncN and clears otherwise.
//    - A value exceeding SKEW_TOL is a complement fault.
//  Not defined:
//    - The skew logic is not generated and no complement fault ever occurs.
//    - ClockN is synchronized but otherwise unused.
//    - All other behaviour is identical.
// TESTING
//  1 Reset held 3 cycles, then released -> ClockOk=0, Fault=0, State=0, LastEdgeCount=0.
//  2 ClockP period 4 Clock cycles, ClockN=~ClockP -> LastEdgeCount=64 each window.
//    ClockOk=1 after the 4th window end (~1024+sync cycles); State=1.
//  3 Locked, then ClockP/ClockN stuck 0 -> at the next window end LastEdgeCount<=small, State=2, ClockOk=0, Fault=1.
//    One window later State=0.
//  4 ClockP period 3 (85 edges/window) -> LastEdgeCount=85, never LOCKED, Fault stays 0.
//  5 Locked, force ClockN=ClockP for 4 cycles -> with macro: State=2 and Fault=1 within 1 cycle of skew count 4.
//    Without macro: State stays 1.
//  6 FaultClear pulsed in the cycle a new fault sets -> Fault stays 1.
//    FaultClear pulsed alone later -> Fault=0 next cycle.

Source files
------------

// File: rtl/xtal_clock_qualifier.sv
// Crystal clock qualifier: counts synchronized ClockP edges per window and declares ClockOk after
// GOOD_WINDOWS good windows. Optional complement check enabled by XTAL_QUAL_COMPLEMENT_CHECK_EN.
`timescale 1ns/1ps
module xtal_clock_qualifier #(
  parameter int unsigned WINDOW       = 256,
  parameter int unsigned MIN_EDGES    = 60,
  parameter int unsigned MAX_EDGES    = 68,
  parameter int unsigned GOOD_WINDOWS = 4,
  parameter int unsigned SKEW_TOL     = 3,
  parameter int unsigned CNT_W        = 9
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ClockP,
  input  logic             ClockN,
  input  logic             FaultClear,
  output logic             ClockOk,
  output logic             Fault,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] LastEdgeCount
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int GW_W  = $clog2(GOOD_WINDOWS + 1);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_EDGES);
  localparam logic [GW_W-1:0]  GOOD_TGT  = GW_W'(GOOD_WINDOWS);

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_e;

  logic             p_meta_q, p_sync_q, p_prev_q;
  logic             n_meta_q, n_sync_q;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [GW_W-1:0]  good_q, good_d;
  state_e           state_q, state_d;
  logic             ok_q, ok_d;
  logic             fault_q, fault_d;

  logic             rise_s;
  logic             win_end_s;
  logic             good_s;
  logic             comp_fault_s;
  logic             fault_set_s;
  logic [CNT_W-1:0] edge_inc_s;

`ifdef XTAL_QUAL_COMPLEMENT_CHECK_EN
  localparam int SK_W = $clog2(SKEW_TOL + 2);
  localparam logic [SK_W-1:0] SKEW_C = SK_W'(SKEW_TOL);
  logic [SK_W-1:0] skew_q, skew_d;

  // Skew run length saturates just above the tolerance so the fault holds while phases agree.
  always_comb begin
    skew_d = skew_q;
    if (p_sync_q == n_sync_q) begin
      if (skew_q > SKEW_C) begin
        skew_d = skew_q;
      end else begin
        skew_d = skew_q + SK_W'(1);
      end
    end else begin
      skew_d = {SK_W{1'b0}};
    end
  end

  assign comp_fault_s = (skew_q > SKEW_C);

  // Skew counter register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      skew_q <= {SK_W{1'b0}};
    end else begin
      skew_q <= skew_d;
    end
  end
`else
  logic unused_n_sync_s;
  assign unused_n_sync_s = n_sync_q;
  assign comp_fault_s    = 1'b0;
`endif

  assign rise_s     = p_sync_q & ~p_prev_q;
  assign win_end_s  = (win_q == WIN_LAST);
  assign edge_inc_s = (rise_s && (edge_q != CNT_MAX)) ? edge_q + CNT_W'(1) : edge_q;
  assign good_s     = (edge_inc_s >= MIN_C) && (edge_inc_s <= MAX_C);

  // Window bookkeeping and qualification state machine next-state logic.
  always_comb begin
    win_d       = win_end_s ? {WIN_W{1'b0}} : win_q + WIN_W'(1);
    edge_d      = win_end_s ? {CNT_W{1'b0}} : edge_inc_s;
    last_d      = win_end_s ? edge_inc_s : last_q;
    good_d      = good_q;
    state_d     = state_q;
    fault_set_s = 1'b0;
    case (state_q)
      WARMUP: begin
        if (comp_fault_s) begin
          good_d = {GW_W{1'b0}};
        end else if (win_end_s) begin
          if (!good_s) begin
            good_d = {GW_W{1'b0}};
          end else if (good_q + GW_W'(1) == GOOD_TGT) begin
            good_d  = {GW_W{1'b0}};
            state_d = LOCKED;
          end else begin
            good_d = good_q + GW_W'(1);
          end
        end else begin
          good_d = good_q;
        end
      end
      LOCKED: begin
        good_d = {GW_W{1'b0}};
        // A complement fault outranks a coincident window end and restarts the window.
        if (comp_fault_s) begin
          state_d     = FAULT;
          fault_set_s = 1'b1;
          win_d       = {WIN_W{1'b0}};
          edge_d      = {CNT_W{1'b0}};
          last_d      = last_q;
        end else if (win_end_s && !good_s) begin
          state_d     = FAULT;
          fault_set_s = 1'b1;
        end else begin
          state_d = LOCKED;
        end
      end
      FAULT: begin
        good_d = {GW_W{1'b0}};
        if (win_end_s) begin
          state_d = WARMUP;
        end else begin
          state_d = FAULT;
        end
      end
      default: begin
        good_d  = {GW_W{1'b0}};
        state_d = WARMUP;
      end
    endcase

    ok_d = (state_d == LOCKED);
    if (fault_set_s) begin
      fault_d = 1'b1;
    end else if (FaultClear) begin
      fault_d = 1'b0;
    end else begin
      fault_d = fault_q;
    end
  end

  // Synchronizers, counters and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      p_meta_q <= 1'b0;
      p_sync_q <= 1'b0;
      p_prev_q <= 1'b0;
      n_meta_q <= 1'b0;
      n_sync_q <= 1'b0;
      win_q    <= {WIN_W{1'b0}};
      edge_q   <= {CNT_W{1'b0}};
      last_q   <= {CNT_W{1'b0}};
      good_q   <= {GW_W{1'b0}};
      state_q  <= WARMUP;
      ok_q     <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      p_meta_q <= ClockP;
      p_sync_q <= p_meta_q;
      p_prev_q <= p_sync_q;
      n_meta_q <= ClockN;
      n_sync_q <= n_meta_q;
      win_q    <= win_d;
      edge_q   <= edge_d;
      last_q   <= last_d;
      good_q   <= good_d;
      state_q  <= state_d;
      ok_q     <= ok_d;
      fault_q  <= fault_d;
    end
  end

  assign ClockOk       = ok_q;
  assign Fault         = fault_q;
  assign State         = state_q;
  assign LastEdgeCount = last_q;

endmodule

// File: tb/tb_xtal_clock_qualifier.sv
// Scoreboard bench for xtal_clock_qualifier: stimulus queues expected outputs per reference-clock
// cycle, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_xtal_clock_qualifier;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       ClockP = 1'b0;
  logic       ClockN = 1'b1;
  logic       FaultClear = 1'b0;
  logic       ClockOk;
  logic       Fault;
  logic [1:0] State;
  logic [8:0] LastEdgeCount;

  xtal_clock_qualifier dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .ClockP        (ClockP),
    .ClockN        (ClockN),
    .FaultClear    (FaultClear),
    .ClockOk       (ClockOk),
    .Fault         (Fault),
    .State         (State),
    .LastEdgeCount (LastEdgeCount)
  );

  typedef struct {
    int         at;
    logic [1:0] st;
    logic       ok;
    logic       flt;
    int         lo;
    int         hi;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   osc_mode = 1;   // 0 stopped, 1 period 4, 2 period 3
  bit   force_eq = 1'b0;

  initial forever #5 Clock = ~Clock;

  // Cycles since reset release: after the k-th active edge cyc == k.
  initial forever begin
    @(posedge Clock);
    if (Reset) cyc = 0;
    else cyc = cyc + 1;
  end

  // Oscillator model, changing only on the falling edge of the reference clock.
  initial forever begin
    logic p;
    @(negedge Clock);
    case (osc_mode)
      1: p = ((cyc % 4) < 2);
      2: p = ((cyc % 3) == 0);
      default: p = 1'b0;
    endcase
    ClockP = p;
    ClockN = force_eq ? p : ~p;
  end

  // Monitor: compare every expectation whose cycle has arrived.
  initial forever begin
    @(negedge Clock);
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      bit   cnt_ok;
      e = sb.pop_front();
      checks = checks + 1;
      cnt_ok = (int'(LastEdgeCount) >= e.lo) && (int'(LastEdgeCount) <= e.hi);
      if (e.at != cyc) begin
        errors = errors + 1;
        $display("FAIL %s: expectation for cycle %0d reached only at cycle %0d", e.name, e.at, cyc);
      end else if (State !== e.st || ClockOk !== e.ok || Fault !== e.flt || !cnt_ok) begin
        errors = errors + 1;
        $display("FAIL %s @cyc %0d: got State=%0d ClockOk=%0b Fault=%0b LastEdgeCount=%0d, expected State=%0d ClockOk=%0b Fault=%0b LastEdgeCount in [%0d,%0d]",
                 e.name, cyc, State, ClockOk, Fault, LastEdgeCount, e.st, e.ok, e.flt, e.lo, e.hi);
      end
    end
  end

  task automatic push(input int at, input logic [1:0] st, input logic ok, input logic flt,
                      input int lo, input int hi, input string name);
    exp_t e;
    e.at = at; e.st = st; e.ok = ok; e.flt = flt; e.lo = lo; e.hi = hi; e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 5000) begin
      @(posedge Clock);
      #1;
      guard++;
    end
    if (cyc != n) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL wait_cyc: cycle %0d never reached (at %0d)", n, cyc);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 2000) begin
      @(negedge Clock);
      guard++;
    end
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    push(0, 2'd0, 1'b0, 1'b0, 0, 0, "reset_state");
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    push(1, 2'd0, 1'b0, 1'b0, 0, 0, "after_release");
  endtask

  initial begin
    // Lock on a period-4 oscillator (64 edges per window).
    osc_mode = 1;
    do_reset();
    push(256,  2'd0, 1'b0, 1'b0, 64, 64, "win1");
    push(512,  2'd0, 1'b0, 1'b0, 64, 64, "win2");
    push(768,  2'd0, 1'b0, 1'b0, 64, 64, "win3");
    push(1023, 2'd0, 1'b0, 1'b0, 64, 64, "prelock");
    push(1024, 2'd1, 1'b1, 1'b0, 64, 64, "lock");
    // Oscillator stops at cycle 1100: 19 edges in window 5, fault with simultaneous clear.
    push(1279, 2'd1, 1'b1, 1'b0, 64, 64, "locked_pre_stop");
    push(1280, 2'd2, 1'b0, 1'b1, 19, 19, "stop_fault_set_wins");
    push(1535, 2'd2, 1'b0, 1'b1, 19, 19, "fault_hold");
    push(1536, 2'd0, 1'b0, 1'b1, 0, 0, "fault_exit");
    push(1600, 2'd0, 1'b0, 1'b1, 0, 0, "fault_sticky");
    push(1601, 2'd0, 1'b0, 1'b0, 0, 0, "fault_cleared");
    push(1792, 2'd0, 1'b0, 1'b0, 0, 0, "warmup_bad_no_fault");
    wait_cyc(1100); osc_mode = 0;
    wait_cyc(1279); FaultClear = 1'b1;
    wait_cyc(1280); FaultClear = 1'b0;
    wait_cyc(1600); FaultClear = 1'b1;
    wait_cyc(1601); FaultClear = 1'b0;
    wait_cyc(1800);
    drain();

    // Mid-window reset, then period-3 oscillator: too many edges, never locks.
    osc_mode = 2;
    do_reset();
    push(255,  2'd0, 1'b0, 1'b0, 0, 0, "p3_partial");
    push(256,  2'd0, 1'b0, 1'b0, 85, 85, "p3_win1");
    push(512,  2'd0, 1'b0, 1'b0, 85, 85, "p3_win2");
    push(768,  2'd0, 1'b0, 1'b0, 86, 86, "p3_win3");
    push(1024, 2'd0, 1'b0, 1'b0, 85, 85, "p3_win4");
    push(1280, 2'd0, 1'b0, 1'b0, 85, 85, "p3_never_lock");
    wait_cyc(1290);
    drain();

    // Lock again, then force ClockN equal to ClockP for 4 cycles.
    osc_mode = 1;
    do_reset();
    push(1024, 2'd1, 1'b1, 1'b0, 64, 64, "relock");
`ifdef XTAL_QUAL_COMPLEMENT_CHECK_EN
    push(1106, 2'd1, 1'b1, 1'b0, 64, 64, "skew_pre");
    push(1107, 2'd2, 1'b0, 1'b1, 64, 64, "skew_fault");
    push(1362, 2'd2, 1'b0, 1'b1, 64, 64, "skew_fault_hold");
    push(1363, 2'd0, 1'b0, 1'b1, 64, 64, "skew_fault_exit");
`else
    push(1107, 2'd1, 1'b1, 1'b0, 64, 64, "skew_ignored");
    push(1280, 2'd1, 1'b1, 1'b0, 64, 64, "skew_still_locked");
`endif
    wait_cyc(1100); force_eq = 1'b1;
    wait_cyc(1104); force_eq = 1'b0;
    wait_cyc(1400);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
